// File: rtl/oshot_arb.sv
// Round-robin arbiter sharing one pulse resource: rising edges become pending
// requests, one-hot grant pulses are separated by a programmable holdoff window.
module oshot_arb #(
  parameter int NREQ   = 4,
  parameter int HOLD_W = 8,
  parameter int ID_W   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [HOLD_W-1:0] holdoff,
  output logic [NREQ-1:0]   gnt,
  output logic [ID_W-1:0]   gnt_id,
  output logic              busy,
  output logic [NREQ-1:0]   pend,
  output logic              lost
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state, state_nxt;
  logic [NREQ-1:0]   req_q;
  logic [HOLD_W-1:0] cnt, cnt_nxt;
  logic [ID_W-1:0]   last, last_nxt;
  logic [NREQ-1:0]   rise, cand, win_oh;
  logic [NREQ-1:0]   gnt_nxt, pend_nxt;
  logic [ID_W-1:0]   win, id_nxt;
  logic              found, lost_nxt;
  int unsigned       idx;

  always_comb begin
    rise  = req & ~req_q;
    cand  = pend | rise;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    // Search from last+1 upward, wrapping explicitly so non-power-of-two NREQ
    // never lands on an unused index.
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = 32'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && cand[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;

    gnt_nxt  = '0;
    id_nxt   = gnt_id;
    last_nxt = last;
    cnt_nxt  = cnt;
    pend_nxt = pend | rise;
    lost_nxt = |(rise & pend);

    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt  = win_oh;
          id_nxt   = win;
          last_nxt = win;
          cnt_nxt  = holdoff;
          pend_nxt = cand & ~win_oh;
        end
      end
      HOLD: begin
        cnt_nxt = cnt - HOLD_W'(1);
      end
      default: ;
    endcase

    state_nxt = (cnt_nxt != '0) ? HOLD : IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      req_q  <= '0;
      cnt    <= '0;
      last   <= ID_W'(NREQ - 1);
      gnt    <= '0;
      gnt_id <= '0;
      pend   <= '0;
      lost   <= 1'b0;
    end else begin
      state  <= state_nxt;
      req_q  <= req;
      cnt    <= cnt_nxt;
      last   <= last_nxt;
      gnt    <= gnt_nxt;
      gnt_id <= id_nxt;
      pend   <= pend_nxt;
      lost   <= lost_nxt;
    end
  end

  assign busy = (state == HOLD);

endmodule

// File: tb/tb_oshot_arb.sv
// Scoreboard bench for oshot_arb: a 4-source instance against a cycle model and
// a 3-source instance checking round-robin wrap order.
module tb_oshot_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [7:0] holdoff;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic [3:0] pend;
  logic       lost;

  logic [2:0] req3;
  logic [7:0] holdoff3;
  logic [2:0] gnt3;
  logic [1:0] gnt_id3;
  logic       busy3;
  logic [2:0] pend3;
  logic       lost3;

  always #5 clk = ~clk;

  oshot_arb #(.NREQ(4), .HOLD_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .holdoff(holdoff),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .pend(pend), .lost(lost)
  );

  oshot_arb #(.NREQ(3), .HOLD_W(8)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .holdoff(holdoff3),
    .gnt(gnt3), .gnt_id(gnt_id3), .busy(busy3), .pend(pend3), .lost(lost3)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic [3:0] pend;
    logic       lost;
  } exp_t;

  exp_t sb[$];
  int   exp3[$];
  int   checks = 0;
  int   failures = 0;

  logic [3:0] m_req_q, m_pend, m_gnt;
  logic [1:0] m_id;
  logic       m_lost;
  int         m_cnt, m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs after the coming edge, computed from the driven inputs.
  task automatic model_step();
    logic [3:0] rise, cand;
    int j;
    exp_t e;
    if (reset) begin
      m_req_q = '0; m_pend = '0; m_cnt = 0; m_last = 3;
      m_gnt = '0; m_id = '0; m_lost = 1'b0;
    end else begin
      rise    = req & ~m_req_q;
      cand    = m_pend | rise;
      m_lost  = |(rise & m_pend);
      m_req_q = req;
      m_gnt   = '0;
      if (m_cnt > 0) begin
        m_cnt  = m_cnt - 1;
        m_pend = m_pend | rise;
      end else if (cand == 4'b0) begin
        m_pend = cand;
      end else begin
        j = m_last;
        do j = (j + 1) % 4; while (!cand[j]);
        m_gnt  = 4'(1 << j);
        m_id   = j[1:0];
        m_last = j;
        m_cnt  = int'(holdoff);
        m_pend = cand & ~m_gnt;
      end
    end
    e.gnt  = m_gnt;
    e.id   = m_id;
    e.busy = (m_cnt != 0);
    e.pend = m_pend;
    e.lost = m_lost;
    sb.push_back(e);
  endtask

  task automatic tick(input logic r, input logic [3:0] rq, input logic [7:0] ho);
    exp_t e;
    int id;
    reset   = r;
    req     = rq;
    holdoff = ho;
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("gnt",    32'(gnt),    32'(e.gnt));
    check("gnt_id", 32'(gnt_id), 32'(e.id));
    check("busy",   32'(busy),   32'(e.busy));
    check("pend",   32'(pend),   32'(e.pend));
    check("lost",   32'(lost),   32'(e.lost));
    if (gnt3 != 3'b0) begin
      if (exp3.size() == 0) begin
        check("gnt3_extra", 32'(gnt3), 32'(0));
      end else begin
        id = exp3.pop_front();
        check("gnt3_id", 32'(gnt_id3), 32'(id));
        check("gnt3_oh", 32'(gnt3), 32'(1 << id));
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; holdoff = '0; req3 = '0; holdoff3 = '0;

    // Single source, holdoff 3, level held high.
    tick(1, 4'h0, 8'd3); tick(1, 4'h0, 8'd3);
    tick(0, 4'h0, 8'd3);
    repeat (8) tick(0, 4'h1, 8'd3);

    // All rise together, holdoff 0; 3-source instance wraps 0,1,2,0,1,2.
    repeat (4) tick(0, 4'h0, 8'd0);
    req3 = 3'b111; exp3.push_back(0); exp3.push_back(1); exp3.push_back(2);
    repeat (6) tick(0, 4'hf, 8'd0);
    req3 = 3'b000;
    tick(0, 4'h0, 8'd0);
    req3 = 3'b111; exp3.push_back(0); exp3.push_back(1); exp3.push_back(2);
    repeat (5) tick(0, 4'h0, 8'd0);
    req3 = 3'b000;

    // Rise during HOLD waits for the window to close.
    repeat (2) tick(0, 4'h0, 8'd2);
    tick(0, 4'h1, 8'd2);
    repeat (6) tick(0, 4'h5, 8'd2);
    repeat (2) tick(0, 4'h0, 8'd2);

    // Pending source re-edges while blocked -> lost pulse, single grant.
    repeat (2) tick(0, 4'h0, 8'd5);
    tick(0, 4'h1, 8'd5);
    tick(0, 4'h3, 8'd5);
    tick(0, 4'h1, 8'd5);
    repeat (10) tick(0, 4'h3, 8'd5);
    repeat (3) tick(0, 4'h0, 8'd5);

    // Reset mid-HOLD with pending work, req held across release.
    tick(0, 4'h1, 8'd5);
    repeat (2) tick(0, 4'h7, 8'd5);
    tick(1, 4'h7, 8'd5);
    repeat (3) tick(0, 4'h7, 8'd5);

    // Holdoff change during HOLD, then random traffic.
    tick(0, 4'h0, 8'd4);
    tick(0, 4'h8, 8'd4);
    repeat (6) tick(0, 4'h8, 8'd0);
    repeat (80) tick($urandom_range(0, 19) == 0, 4'($urandom), 8'($urandom_range(0, 3)));

    check("gnt3_count", 32'(exp3.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
